// File: rtl/mt9v032_sync_decoder_if.sv
// Bit-stream input and decoded video timing/pixel outputs of mt9v032_sync_decoder.
// Defining MT9V032_DEC_STATS_EN adds the frame/error statistics signals.
interface mt9v032_sync_decoder_if #(
    parameter int XW = 10,
    parameter int YW = 10
);
    logic          bit_in;
    logic          bit_valid;
    logic          locked;
    logic          frame_valid;
    logic          line_valid;
    logic          px_valid;
    logic [9:0]    px_data;
    logic [XW-1:0] px_x;
    logic [YW-1:0] px_y;
    logic          sof;
    logic          eol;
    logic          eof;
    logic          sync_err;
`ifdef MT9V032_DEC_STATS_EN
    logic [15:0]   frame_cnt;
    logic [15:0]   ferr_cnt;
    logic [XW-1:0] last_line_len;

    modport master (
        output bit_in, bit_valid,
        input  locked, frame_valid, line_valid,
        input  px_valid, px_data, px_x, px_y,
        input  sof, eol, eof, sync_err,
        input  frame_cnt, ferr_cnt, last_line_len
    );

    modport slave (
        input  bit_in, bit_valid,
        output locked, frame_valid, line_valid,
        output px_valid, px_data, px_x, px_y,
        output sof, eol, eof, sync_err,
        output frame_cnt, ferr_cnt, last_line_len
    );
`else
    modport master (
        output bit_in, bit_valid,
        input  locked, frame_valid, line_valid,
        input  px_valid, px_data, px_x, px_y,
        input  sof, eol, eof, sync_err
    );

    modport slave (
        input  bit_in, bit_valid,
        output locked, frame_valid, line_valid,
        output px_valid, px_data, px_x, px_y,
        output sof, eol, eof, sync_err
    );
`endif
endinterface

// File: rtl/mt9v032_sync_decoder.sv
// MT9V032/MT9V034 embedded-sync receiver: word alignment, sync decode, pixel x/y.
// Define MT9V032_DEC_STATS_EN to add frame_cnt, ferr_cnt and last_line_len.
module mt9v032_sync_decoder #(
    parameter int LOCK_WORDS = 4,
    parameter int LOSS_WORDS = 2,
    parameter int XW         = 10,
    parameter int YW         = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    mt9v032_sync_decoder_if.slave bus
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [9:0] W_LS    = 10'd1;
    localparam logic [9:0] W_LE    = 10'd2;
    localparam logic [9:0] W_FE    = 10'd3;
    localparam logic [9:0] W_FS_HI = 10'd1023;
    localparam logic [9:0] W_FS_LO = 10'd0;

    state_t        state;
    state_t        state_n;
    logic [10:0]   sr;
    logic [11:0]   sr_n;
    logic [3:0]    phase;
    logic [3:0]    phase_n;
    logic [7:0]    good_cnt;
    logic [7:0]    good_cnt_n;
    logic [7:0]    bad_cnt;
    logic [7:0]    bad_cnt_n;

    logic          cand;
    logic [9:0]    word;
    logic          at_word;
    logic          take;
    logic          bad_lk;
    logic          lose;

    logic          fv;
    logic          fv_n;
    logic          lv;
    logic          lv_n;
    logic          pxv;
    logic          pxv_n;
    logic [9:0]    pxd;
    logic [9:0]    pxd_n;
    logic [XW-1:0] pxx;
    logic [XW-1:0] pxx_n;
    logic [XW-1:0] col;
    logic [XW-1:0] col_n;
    logic [YW-1:0] pxy;
    logic [YW-1:0] pxy_n;
    logic          sof_q;
    logic          sof_n;
    logic          eol_q;
    logic          eol_n;
    logic          eof_q;
    logic          eof_n;
    logic          err_q;
    logic          err_n;
    logic [9:0]    h1;
    logic [9:0]    h1_n;
    logic [9:0]    h2;
    logic [9:0]    h2_n;
    logic [1:0]    hv;
    logic [1:0]    hv_n;

    logic          fe_hit;
    logic          fs_hit;
    logic          ls_hit;
    logic          orphan;

    // sr keeps only the upper 11 bits; sr_n is the full window after this bit
    assign sr_n    = {bus.bit_in, sr};
    assign cand    = sr_n[0] & ~sr_n[11];
    assign word    = sr_n[10:1];
    assign at_word = bus.bit_valid && (state != HUNT) && (phase == 4'd11);
    assign take    = at_word && (state == LOCKED) && cand;
    assign bad_lk  = at_word && (state == LOCKED) && !cand;
    assign lose    = bad_lk && ((bad_cnt + 8'd1) == 8'(LOSS_WORDS));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= HUNT;
            sr       <= '0;
            phase    <= '0;
            good_cnt <= '0;
            bad_cnt  <= '0;
        end else begin
            state    <= state_n;
            phase    <= phase_n;
            good_cnt <= good_cnt_n;
            bad_cnt  <= bad_cnt_n;
            if (bus.bit_valid) begin
                sr <= sr_n[11:1];
            end
        end
    end

    always_comb begin
        state_n    = state;
        phase_n    = phase;
        good_cnt_n = good_cnt;
        bad_cnt_n  = bad_cnt;
        if (bus.bit_valid) begin
            unique case (state)
                HUNT: begin
                    if (cand) begin
                        state_n    = VERIFY;
                        phase_n    = '0;
                        good_cnt_n = 8'd1;
                    end
                end
                VERIFY: begin
                    if (phase == 4'd11) begin
                        phase_n = '0;
                        if (cand) begin
                            good_cnt_n = good_cnt + 8'd1;
                            if (good_cnt_n == 8'(LOCK_WORDS)) begin
                                state_n   = LOCKED;
                                bad_cnt_n = '0;
                            end
                        end else begin
                            state_n = HUNT;
                        end
                    end else begin
                        phase_n = phase + 4'd1;
                    end
                end
                LOCKED: begin
                    if (phase == 4'd11) begin
                        phase_n = '0;
                        if (cand) begin
                            bad_cnt_n = '0;
                        end else begin
                            bad_cnt_n = bad_cnt + 8'd1;
                            if (lose) begin
                                state_n = HUNT;
                            end
                        end
                    end else begin
                        phase_n = phase + 4'd1;
                    end
                end
                default: state_n = HUNT;
            endcase
        end
    end

    assign fs_hit = (hv == 2'b11) && (h2 == W_FS_HI) &&
                    (h1 == W_FS_LO) && (word == W_FS_HI);
    assign fe_hit = (word == W_FE) && fv;
    assign ls_hit = (word == W_LS) && fv;
    assign orphan = ((word == W_LS) || (word == W_FE)) && !fv;

    always_comb begin
        fv_n  = fv;
        lv_n  = lv;
        pxd_n = pxd;
        pxx_n = pxx;
        pxy_n = pxy;
        col_n = col;
        h1_n  = h1;
        h2_n  = h2;
        hv_n  = hv;
        pxv_n = 1'b0;
        sof_n = 1'b0;
        eol_n = 1'b0;
        eof_n = 1'b0;
        err_n = 1'b0;
        if (bad_lk) begin
            hv_n = 2'b00;
        end
        if (lose && (fv || lv)) begin
            fv_n  = 1'b0;
            lv_n  = 1'b0;
            err_n = 1'b1;
        end
        if (take) begin
            h1_n = word;
            h2_n = h1;
            hv_n = {hv[0], 1'b1};
            if (lv) begin
                if (word == W_LE) begin
                    lv_n  = 1'b0;
                    eol_n = 1'b1;
                    pxy_n = pxy + YW'(1);
                end else begin
                    pxv_n = 1'b1;
                    pxd_n = word;
                    pxx_n = col;
                    col_n = col + XW'(1);
                end
            end else begin
                // a restart inside a frame reports both the new sof and the error
                unique case (1'b1)
                    fe_hit: begin
                        fv_n  = 1'b0;
                        eof_n = 1'b1;
                    end
                    fs_hit: begin
                        fv_n  = 1'b1;
                        sof_n = 1'b1;
                        err_n = fv;
                        pxy_n = '0;
                    end
                    ls_hit: begin
                        lv_n  = 1'b1;
                        pxx_n = '0;
                        col_n = '0;
                    end
                    orphan: begin
                        err_n = 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fv    <= 1'b0;
            lv    <= 1'b0;
            pxv   <= 1'b0;
            pxd   <= '0;
            pxx   <= '0;
            pxy   <= '0;
            col   <= '0;
            sof_q <= 1'b0;
            eol_q <= 1'b0;
            eof_q <= 1'b0;
            err_q <= 1'b0;
            h1    <= '0;
            h2    <= '0;
            hv    <= 2'b00;
        end else begin
            fv    <= fv_n;
            lv    <= lv_n;
            pxv   <= pxv_n;
            pxd   <= pxd_n;
            pxx   <= pxx_n;
            pxy   <= pxy_n;
            col   <= col_n;
            sof_q <= sof_n;
            eol_q <= eol_n;
            eof_q <= eof_n;
            err_q <= err_n;
            h1    <= h1_n;
            h2    <= h2_n;
            hv    <= hv_n;
        end
    end

    assign bus.locked      = (state == LOCKED);
    assign bus.frame_valid = fv;
    assign bus.line_valid  = lv;
    assign bus.px_valid    = pxv;
    assign bus.px_data     = pxd;
    assign bus.px_x        = pxx;
    assign bus.px_y        = pxy;
    assign bus.sof         = sof_q;
    assign bus.eol         = eol_q;
    assign bus.eof         = eof_q;
    assign bus.sync_err    = err_q;

`ifdef MT9V032_DEC_STATS_EN
    logic [15:0]   frame_cnt;
    logic [15:0]   ferr_cnt;
    logic [XW-1:0] line_len;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
            ferr_cnt  <= '0;
            line_len  <= '0;
        end else begin
            if (eof_n) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (bad_lk && (ferr_cnt != 16'hFFFF)) begin
                ferr_cnt <= ferr_cnt + 16'd1;
            end
            if (eol_n) begin
                line_len <= pxx + XW'(1);
            end
        end
    end

    assign bus.frame_cnt     = frame_cnt;
    assign bus.ferr_cnt      = ferr_cnt;
    assign bus.last_line_len = line_len;
`endif

endmodule
